// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small register bank, oversampled in the clk_s domain.
// Optional macro SPI_SLAVE_AUTOINC_EN: multi-word bursts with auto-incrementing address.
module spi_slave_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_NUM    = 8
) (
   input  logic                  clk_s,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [6:0]            host_addr,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  wr_valid,
   output logic [6:0]            wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  finish,
   output logic [1:0]            dbg_state
);

   localparam int         AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam int         CW      = $clog2(DATA_WIDTH + 8) + 1;
   localparam logic [7:0] REG_LIM = 8'(REG_NUM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] regs [REG_NUM];

   logic [1:0]            sclk_sync, cs_sync, mosi_sync;
   logic                  sclk_q, cs_q;
   logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

   logic [CW-1:0]         bit_cnt;
   logic [6:0]            cmd_shift;
   logic [6:0]            addr;
   logic                  is_write;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] tx_shift;

   logic [6:0]            cmd_addr;
   logic [6:0]            addr_inc;
   logic [DATA_WIDTH-1:0] rx_word;

   function automatic logic in_range(input logic [6:0] a);
      return ({1'b0, a} < REG_LIM);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [6:0] a);
      return in_range(a) ? regs[a[AW-1:0]] : '0;
   endfunction

   assign sclk_rise = sclk_sync[1] & ~sclk_q;
   assign sclk_fall = ~sclk_sync[1] & sclk_q;
   assign cs_rise   = cs_sync[1] & ~cs_q;
   assign cs_fall   = ~cs_sync[1] & cs_q;
   assign mosi_s    = mosi_sync[1];

   assign cmd_addr  = {cmd_shift[5:0], mosi_s};
   assign addr_inc  = addr + 7'd1;
   assign rx_word   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
   assign dbg_state = state;

   always_comb begin
      host_rdata = '0;
      if (in_range(host_addr)) host_rdata = regs[host_addr[AW-1:0]];
   end

   // cs_n resets to the deasserted level so a held-low chip select after reset reads as a new frame
   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= 2'b00;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], sclk};
         cs_sync   <= {cs_sync[0], cs_n};
         mosi_sync <= {mosi_sync[0], mosi};
         sclk_q    <= sclk_sync[1];
         cs_q      <= cs_sync[1];
      end
   end

   always_ff @(posedge clk_s or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         miso      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         finish    <= 1'b0;
         bit_cnt   <= '0;
         cmd_shift <= '0;
         addr      <= '0;
         is_write  <= 1'b0;
         word_done <= 1'b0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         finish   <= 1'b0;
         // Chip-select release wins over any coincident sclk edge, dropping a partial word
         if (cs_rise) begin
            state     <= IDLE;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            finish    <= word_done;
            word_done <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  miso <= 1'b0;
                  if (cs_fall) begin
                     state     <= CMD;
                     bit_cnt   <= '0;
                     word_done <= 1'b0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     cmd_shift <= {cmd_shift[5:0], mosi_s};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == CW'(7)) begin
                        is_write <= cmd_shift[6];
                        addr     <= cmd_addr;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        if (!cmd_shift[6]) tx_shift <= rd_word(cmd_addr);
                     end
                  end
               end
               DATA: begin
                  if (sclk_fall && !is_write) begin
                     miso     <= tx_shift[DATA_WIDTH-1];
                     tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     rx_shift <= rx_word;
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        word_done <= 1'b1;
                        bit_cnt   <= '0;
                        if (is_write && in_range(addr)) begin
                           regs[addr[AW-1:0]] <= rx_word;
                           wr_valid           <= 1'b1;
                           wr_addr            <= addr;
                           wr_data            <= rx_word;
                        end
`ifdef SPI_SLAVE_AUTOINC_EN
                        addr <= addr_inc;
                        if (!is_write) tx_shift <= rd_word(addr_inc);
`else
                        state <= DONE;
                        miso  <= 1'b0;
`endif
                     end
                  end
               end
               DONE: begin
                  miso <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  miso  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomized bench for spi_slave_regfile: an SPI master driver, a register-bank
// reference model, and a scoreboard for write commits and frame-finish pulses.
module tb_spi_slave_regfile;

   localparam int DW   = 8;
   localparam int RN   = 8;
   localparam int HALF = 6;
`ifdef SPI_SLAVE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic          clk_s, rst_n, sclk, cs_n, mosi, miso;
   logic [6:0]    host_addr;
   logic [DW-1:0] host_rdata;
   logic          wr_valid, finish;
   logic [6:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    dbg_state;

   spi_slave_regfile #(.DATA_WIDTH(DW), .REG_NUM(RN)) dut (
      .clk_s(clk_s), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .host_addr(host_addr), .host_rdata(host_rdata), .wr_valid(wr_valid),
      .wr_addr(wr_addr), .wr_data(wr_data), .finish(finish), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mem [RN];
   logic [DW-1:0] tx_words [8];
   logic [14:0]   exp_wr_q [$];
   logic          exp_fin_q [$];
   logic [6:0]    last_wr_addr;
   logic [DW-1:0] last_wr_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: pops an expectation for every output pulse
   initial begin
      logic [14:0] e;
      forever begin
         @(negedge clk_s);
         if (rst_n && wr_valid) begin
            if (exp_wr_q.size() == 0) check("unexpected_wr_valid", {wr_addr, wr_data}, 15'h0);
            else begin
               e = exp_wr_q.pop_front();
               check("wr_commit", {17'h0, wr_addr, wr_data}, {17'h0, e});
            end
         end
         if (rst_n && finish) begin
            if (exp_fin_q.size() == 0) check("unexpected_finish", 32'(finish), 32'h0);
            else begin
               void'(exp_fin_q.pop_front());
               check("finish_pulse", 32'(finish), 32'h1);
            end
         end
      end
   end

   task automatic sclk_bit(input logic b, input bit raise_cs, output logic m);
      mosi = b;
      repeat (HALF) @(negedge clk_s);
      m    = miso;
      sclk = 1'b1;
      if (raise_cs) cs_n = 1'b1;
      repeat (HALF) @(negedge clk_s);
      sclk = 1'b0;
   endtask

   // One frame: ncmd command bits, nwords full data words, tail partial bits.
   // cs_last raises cs_n together with the final rising sclk edge of the last word.
   task automatic spi_frame(input logic [7:0] cmd, input int ncmd, input int nwords,
                            input int tail, input bit cs_last);
      logic          w, m, active;
      logic [6:0]    a, ak;
      int            complete;
      logic [DW-1:0] exp_rd [8];
      logic [DW-1:0] got;
      w = cmd[7];
      a = cmd[6:0];
      complete = (ncmd == 8) ? nwords - (cs_last ? 1 : 0) : 0;
      for (int k = 0; k < nwords; k++) begin
         ak     = AUTOINC ? a + 7'(k) : a;
         active = AUTOINC || (k == 0);
         exp_rd[k] = (!w && active && ak < RN) ? mem[ak[2:0]] : '0;
         if (w && active && k < complete && ak < RN) begin
            exp_wr_q.push_back({ak, tx_words[k]});
            mem[ak[2:0]] = tx_words[k];
            last_wr_addr = ak;
            last_wr_data = tx_words[k];
         end
      end
      if (complete > 0) exp_fin_q.push_back(1'b1);

      cs_n = 1'b0;
      repeat (HALF) @(negedge clk_s);
      for (int i = 0; i < ncmd; i++) sclk_bit(cmd[7-i], 1'b0, m);
      for (int k = 0; k < nwords; k++) begin
         got = '0;
         for (int i = 0; i < DW; i++) begin
            sclk_bit(w ? tx_words[k][DW-1-i] : 1'($urandom_range(0, 1)),
                     cs_last && (k == nwords - 1) && (i == DW - 1), m);
            got = {got[DW-2:0], m};
         end
         check("miso_word", 32'(got), 32'(exp_rd[k]));
      end
      for (int i = 0; i < tail; i++) sclk_bit(1'($urandom_range(0, 1)), 1'b0, m);
      repeat (HALF) @(negedge clk_s);
      cs_n = 1'b1;
      repeat (20) @(negedge clk_s);
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("fin_queue_drained", exp_fin_q.size(), 0);
      check("idle_after_frame", 32'(dbg_state), 32'h0);
   endtask

   task automatic check_host(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         host_addr = 7'(i);
         #1;
         check($sformatf("host_rdata[%0d]", i), 32'(host_rdata), (i < RN) ? 32'(mem[i[2:0]]) : 32'h0);
      end
   endtask

   initial begin
      logic m;
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; host_addr = '0;
      last_wr_addr = '0; last_wr_data = '0;
      for (int i = 0; i < RN; i++) mem[i] = '0;
      repeat (5) @(negedge clk_s);
      check("rst_miso", 32'(miso), 0);
      check("rst_state", 32'(dbg_state), 0);
      check("rst_wr_valid", 32'(wr_valid), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_finish", 32'(finish), 0);
      check_host(0, RN - 1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_s);

      // directed write then read back on miso
      tx_words[0] = 8'hB4;
      spi_frame(8'h83, 8, 1, 0, 1'b0);
      check_host(3, 3);
      spi_frame(8'h03, 8, 1, 0, 1'b0);
      check_host(3, 3);

      // aborted data word, then a full frame to the same register
      tx_words[0] = 8'h00;
      spi_frame(8'h85, 8, 0, 5, 1'b0);
      check_host(5, 5);
      spi_frame(8'h85, 4, 0, 0, 1'b0);
      tx_words[0] = 8'h55;
      spi_frame(8'h85, 8, 1, 0, 1'b0);
      check_host(5, 5);

      // out-of-range write and read; last commit stays on wr_addr/wr_data
      tx_words[0] = 8'h12;
      spi_frame(8'hFF, 8, 1, 0, 1'b0);
      check("wr_addr_held", 32'(wr_addr), 32'(last_wr_addr));
      check("wr_data_held", 32'(wr_data), 32'(last_wr_data));
      spi_frame(8'h7F, 8, 1, 0, 1'b0);
      check_host(0, RN - 1);

      // cs_n rising together with the final sclk edge discards the word
      tx_words[0] = 8'h77;
      spi_frame(8'h86, 8, 1, 0, 1'b1);
      check_host(6, 6);

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         int nw, tl;
         logic [7:0] c;
         c  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, RN + 3))};
         nw = $urandom_range(1, 3);
         tl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
         for (int k = 0; k < 8; k++) tx_words[k] = 8'($urandom);
         spi_frame(c, 8, nw, tl, ($urandom_range(0, 5) == 0));
      end
      check_host(0, RN - 1);

`ifdef SPI_SLAVE_AUTOINC_EN
      tx_words[0] = 8'h55;
      tx_words[1] = 8'hAA;
      spi_frame(8'h82, 8, 2, 0, 1'b0);
      spi_frame(8'h02, 8, 2, 0, 1'b0);
      check_host(2, 3);
`endif

      // reset in the middle of a write data word
      tx_words[0] = 8'h3C;
      spi_frame(8'h81, 8, 1, 0, 1'b0);
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk_s);
      for (int i = 0; i < 8; i++) sclk_bit(i == 0 ? 1'b1 : (i == 7), 1'b0, m);
      for (int i = 0; i < 3; i++) sclk_bit(1'b1, 1'b0, m);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < RN; i++) mem[i] = '0;
      last_wr_addr = '0; last_wr_data = '0;
      check("midrst_miso", 32'(miso), 0);
      check("midrst_state", 32'(dbg_state), 0);
      check_host(0, RN - 1);
      cs_n = 1'b1; sclk = 1'b0;
      repeat (3) @(negedge clk_s);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_s);
      tx_words[0] = 8'hC3;
      spi_frame(8'h81, 8, 1, 0, 1'b0);
      spi_frame(8'h01, 8, 1, 0, 1'b0);
      check_host(0, 127);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
SPI mode-0 slave responder with a small register bank, clocked by the slave-side system clock. It oversamples SCLK, CS_N and MOSI and decodes a command byte followed by one data word. It writes that word into the register bank, or shifts a register out on MISO. It is the target-end counterpart for the team's SPI master, and the host side can read the bank through a parallel port.

Parameters:
DATA_WIDTH, 8, register and data-word width in bits.
REG_NUM, 8, number of registers; valid addresses are 0..REG_NUM-1 (REG_NUM ≤ 128).

Ports:
clk_s  input  1  system clock (slave domain); the only clock of the block.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI serial clock, asynchronous to clk_s, idles low.
cs_n  input  1  SPI chip select, active low, asynchronous.
mosi  input  1  master-out data, MSB first.
miso  output  1  slave-out data, MSB first.
host_addr  input  7  parallel read address.
host_rdata  output  DATA_WIDTH  combinational read of reg[host_addr]; 0 when out of range.
wr_valid  output  1  one-cycle pulse on each committed SPI write.
wr_addr  output  7  address of the committed write; held until the next write.
wr_data  output  DATA_WIDTH  data of the committed write; held until the next write.
finish  output  1  one-cycle pulse when cs_n deasserts after at least one complete data word.

Behaviour:
- Reset (async, rst_n=0): all registers 0, state IDLE, miso=0, wr_valid=0, wr_addr=0, wr_data=0, finish=0, synchronizers cleared with cs_n synced to 1.
- Input synchronization:
  - sclk, cs_n and mosi each pass through a 2-flop synchronizer.
  - Rising and falling sclk edges are detected from the synced value.
  - Edge-to-action latency is 3 clk_s cycles.
  - Requirement on the master: SCLK high and low times are each ≥ 4 clk_s periods.
- Command byte: bit7 = W (1 = write, 0 = read); bits[6:0] = address.
- Frame: 8 command bits followed by DATA_WIDTH data bits. MOSI is sampled on the rising sclk edge; MISO changes on the falling edge.
- States:
  - IDLE: cs_n falling edge → CMD, bit counter cleared.
  - CMD: shift mosi on each rising edge. On the 8th bit, latch W and addr and go to DATA. On a read, load tx_shift with reg[addr], or 0 if addr ≥ REG_NUM.
  - DATA:
    - Read: the falling edge after the last CMD bit drives miso = tx_shift MSB; each later falling edge shifts the next bit out.
    - Write: shift mosi on rising edges.
    - After DATA_WIDTH rising edges, the word is complete. On a write, commit to reg[addr] and pulse wr_valid the following cycle; skip the commit if addr ≥ REG_NUM (no write, no pulse). Then go to DONE.
  - DONE: ignore further sclk edges; miso=0; wait for cs_n high.
- cs_n synced rising edge in any state → IDLE, miso=0, counters cleared.
  - Pulse finish if at least one word completed in this frame.
  - Partial command or partial data is discarded: no register change, no wr_valid.
- miso is 0 whenever the state is not DATA-read.
- Simultaneous cs_n rise and a final rising sclk edge: cs_n wins, and the word is discarded.
- A host read of the same register in the cycle of an SPI commit returns the old value; the new value appears the next cycle.

Optional Feature:
Macro SPI_SLAVE_AUTOINC_EN.
- Defined: after a word completes in DATA, stay in DATA instead of entering DONE. The address increments (wrapping at 127), and each further word is a write or read of the next address.
  - Reads reload tx_shift with the new register at the word boundary, so the stream is contiguous with no gap bit.
  - Out-of-range addresses follow the same rules as single transfers.
- Not defined: single-word transfers only, as described above.

Test Plan:
- Write: frame 0x83,0xB4 → wr_valid one cycle, wr_addr=3, wr_data=0xB4; host_addr=3 gives host_rdata=0xB4; finish pulses after cs_n high.
- Read: after the write, frame 0x03,0x00 → miso bits on the data phase are 1,0,1,1,0,1,0,0; no wr_valid; register 3 unchanged.
- Abort: frame 0x85 then 5 data bits, then cs_n high → reg5 stays 0x00, no wr_valid, no finish; the next full frame 0x85,0x55 writes correctly.
- Out of range (REG_NUM=8): write 0xFF,0x12 → no wr_valid, all regs unchanged; read 0x7F → miso all zero.
- Reset mid-frame: rst_n low during DATA of a write to addr 1 → miso=0 immediately, all regs 0, state IDLE; the next frame works.
- With SPI_SLAVE_AUTOINC_EN: frame 0x82,0x55,0xAA → reg2=0x55, reg3=0xAA, two wr_valid pulses; then read 0x02 with two words → miso 0x55 then 0xAA.
